instr_mem_pipe: RTL and testbench
=================================

Name: instr_mem_pipe

Overview:
- Parametrised, synchronous successor to the combinational instruction ROM used by the single-cycle core.
- Word-addressed instruction store with a request/valid fetch handshake and a programmable wait-state count.
- Write-side load port lets a boot loader, such as the UART loader, fill the program without resynthesis.
- Sits between the PC/fetch stage of the multi-cycle and pipelined cores and the program store.

Parameters:
- ADDR_WIDTH, 8, word-index bits; depth = 2**ADDR_WIDTH words (default 256 words = 1 KiB).
- DATA_WIDTH, 32, instruction width in bits.
- WAIT_CYCLES, 0, extra cycles between request accept and response (0..15).
- NOP_WORD, 32'h00000000, value returned on fault or for a discarded fetch.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- fetch_req  in  1  fetch request; qualified by fetch_ready.
- fetch_addr  in  32  byte address from the PC.
- fetch_ready  out  1  block can accept a fetch this cycle.
- fetch_valid  out  1  one-cycle pulse: fetch_instr/fetch_fault valid.
- fetch_instr  out  DATA_WIDTH  fetched instruction.
- fetch_fault  out  1  misaligned or out-of-range fetch.
- load_en  in  1  write strobe for the program load port.
- load_addr  in  ADDR_WIDTH  word index to write.
- load_data  in  DATA_WIDTH  word to write.
- load_ready  out  1  load port accepts writes this cycle.

Behaviour:
- Reset (reset=0, asynchronous):
  - state=IDLE, fetch_valid=0, fetch_instr=NOP_WORD, fetch_fault=0, wait counter=0.
  - fetch_ready=1 and load_ready=1 once reset deasserts.
  - Memory array is not cleared; contents survive reset.
- FSM states: IDLE, WAIT, RESP.
- IDLE:
  - fetch_ready=1, load_ready=1.
  - A fetch is accepted when fetch_req=1 and load_en=0.
  - Accept latches the word index fetch_addr[ADDR_WIDTH+1:2] and the fault flag.
  - Fault flag = (fetch_addr[1:0]!=0) OR (fetch_addr[31:ADDR_WIDTH+2]!=0).
  - If WAIT_CYCLES=0, next state is RESP; otherwise next state is WAIT with counter=WAIT_CYCLES-1.
- Load priority: load_en=1 in IDLE writes mem[load_addr]<=load_data at that edge. A simultaneous fetch_req is not accepted (fetch_ready=0 that cycle) and must be held by the requester.
- WAIT:
  - fetch_ready=0, load_ready=0; load_en is ignored with no write.
  - Counter decrements each cycle; at 0, next state is RESP.
- RESP: exactly one cycle.
  - fetch_valid=1.
  - fetch_instr = mem[index], or NOP_WORD if faulted.
  - fetch_fault = latched fault flag.
  - Next state is IDLE. fetch_ready=0 and load_ready=0 in RESP, so fetches are strictly non-overlapping.
- Latency: request accepted at edge N gives fetch_valid high during the cycle after edge N+1+WAIT_CYCLES. Sustained throughput is one fetch per WAIT_CYCLES+2 cycles.
- fetch_instr/fetch_fault hold their last response value after fetch_valid falls, until the next RESP.
- Read-after-load: a fetch accepted the cycle after a load to the same index returns the new data.
- Address wrap: none. Indices beyond depth are faults and never alias.
- Reset mid-fetch (WAIT or RESP): the in-flight fetch is discarded, no fetch_valid pulse, return to IDLE.

Optional Feature:
- Macro: INSTR_MEM_PIPE_FAULT_EN.
- Defined:
  - Fault detection as above.
  - Faulted fetches return NOP_WORD with fetch_fault=1.
- Undefined:
  - fetch_fault is tied to 0.
  - Address bits above ADDR_WIDTH+1 and bits [1:0] are ignored: the index wraps modulo depth and misaligned addresses are truncated to the word.

Test Plan:
- Reset, then load mem[0]=32'h20042f5b and mem[1]=32'h2405cfc7, then fetch 0x0 with WAIT_CYCLES=0 -> fetch_valid two edges after accept, fetch_instr=32'h20042f5b, fault=0.
- WAIT_CYCLES=3, fetch 0x4 -> fetch_valid exactly 5 edges after accept, fetch_instr=32'h2405cfc7; fetch_ready=0 and load_ready=0 throughout.
- Same cycle load_en=1 (index 2, 32'h00053400) and fetch_req=1 (0x8) -> write happens, fetch not accepted; next cycle accepted, returns 32'h00053400.
- Fault enabled: fetch 0x6 and 0x400 (depth 256) -> each returns fetch_instr=32'h00000000, fetch_fault=1. Fault disabled: 0x400 returns mem[0].
- Assert reset during WAIT (WAIT_CYCLES=3) -> no fetch_valid pulse, fetch_ready=1 after release, mem[1] still 32'h2405cfc7 on refetch.
- Back-to-back requests held high, WAIT_CYCLES=0 -> one accept every 2 cycles, responses in address order 0x0, 0x4, 0x8.

Source files
------------

// File: rtl/instr_mem_pipe.sv
// Synchronous word-addressed instruction store with request/valid fetch handshake,
// programmable wait states and a boot-loader write port. INSTR_MEM_PIPE_FAULT_EN enables fault detection.
module instr_mem_pipe #(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 32,
    parameter int WAIT_CYCLES = 0,
    parameter logic [DATA_WIDTH-1:0] NOP_WORD = '0
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  fetch_req,
    input  logic [31:0]           fetch_addr,
    output logic                  fetch_ready,
    output logic                  fetch_valid,
    output logic [DATA_WIDTH-1:0] fetch_instr,
    output logic                  fetch_fault,
    input  logic                  load_en,
    input  logic [ADDR_WIDTH-1:0] load_addr,
    input  logic [DATA_WIDTH-1:0] load_data,
    output logic                  load_ready
);

    localparam int DEPTH = 1 << ADDR_WIDTH;
    localparam logic [3:0] WAIT_INIT = (WAIT_CYCLES == 0) ? 4'd0 : 4'(WAIT_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    state_t                  state;
    logic [3:0]              wcnt;
    logic [ADDR_WIDTH-1:0]   idx_p0;
    logic                    fault_p0;
    logic                    vld_p1;
    logic                    accept;
    logic                    acc_fault;
    logic [DATA_WIDTH-1:0]   mem [DEPTH];

`ifdef INSTR_MEM_PIPE_FAULT_EN
    function automatic logic addr_fault(input logic [31:0] a);
        return (a[1:0] != 2'b00) || ((a >> (ADDR_WIDTH + 2)) != 32'd0);
    endfunction

    assign acc_fault = addr_fault(fetch_addr);
`else
    // Without fault detection the index simply wraps and the byte offset is dropped.
    logic unused_addr;
    assign unused_addr = ^{fetch_addr[31:ADDR_WIDTH+2], fetch_addr[1:0]};
    assign acc_fault   = 1'b0;
`endif

    assign accept      = (state == IDLE) && fetch_req && !load_en;
    assign fetch_ready = (state == IDLE) && !load_en;
    assign load_ready  = (state == IDLE);
    assign fetch_valid = vld_p1;

    // Program store: loads only land while idle, and the array is never cleared.
    always_ff @(posedge clk) begin
        if (load_en && (state == IDLE)) begin
            mem[load_addr] <= load_data;
        end
    end

    // Stage p0: latch the accepted word index.
    always_ff @(posedge clk) begin
        if (accept) begin
            idx_p0 <= fetch_addr[ADDR_WIDTH+1:2];
        end
    end

    // Stage p1: sequencing and the registered response.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= IDLE;
            wcnt        <= 4'd0;
            fault_p0    <= 1'b0;
            vld_p1      <= 1'b0;
            fetch_instr <= NOP_WORD;
            fetch_fault <= 1'b0;
        end else begin
            vld_p1 <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        fault_p0 <= acc_fault;
                        if (WAIT_CYCLES == 0) begin
                            state <= RESP;
                        end else begin
                            state <= WAIT;
                            wcnt  <= WAIT_INIT;
                        end
                    end
                end
                WAIT: begin
                    if (wcnt == 4'd0) begin
                        state <= RESP;
                    end else begin
                        wcnt <= wcnt - 4'd1;
                    end
                end
                RESP: begin
                    vld_p1      <= 1'b1;
                    fetch_instr <= fault_p0 ? NOP_WORD : mem[idx_p0];
                    fetch_fault <= fault_p0;
                    state       <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_instr_mem_pipe.sv
// Bench for instr_mem_pipe: two instances (WAIT_CYCLES 0 and 3), directed table, corner
// sequences and random traffic against an array-based reference model.
module tb_instr_mem_pipe;

    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    logic        req   [2];
    logic [31:0] faddr [2];
    logic        rdy   [2];
    logic        vld   [2];
    logic [31:0] ins   [2];
    logic        flt   [2];
    logic        len   [2];
    logic [7:0]  laddr [2];
    logic [31:0] ldata [2];
    logic        lrdy  [2];

    instr_mem_pipe #(.WAIT_CYCLES(0)) u0 (
        .clk(clk), .reset(reset),
        .fetch_req(req[0]), .fetch_addr(faddr[0]), .fetch_ready(rdy[0]),
        .fetch_valid(vld[0]), .fetch_instr(ins[0]), .fetch_fault(flt[0]),
        .load_en(len[0]), .load_addr(laddr[0]), .load_data(ldata[0]), .load_ready(lrdy[0])
    );

    instr_mem_pipe #(.WAIT_CYCLES(3)) u3 (
        .clk(clk), .reset(reset),
        .fetch_req(req[1]), .fetch_addr(faddr[1]), .fetch_ready(rdy[1]),
        .fetch_valid(vld[1]), .fetch_instr(ins[1]), .fetch_fault(flt[1]),
        .load_en(len[1]), .load_addr(laddr[1]), .load_data(ldata[1]), .load_ready(lrdy[1])
    );

    int checks = 0;
    int errors = 0;
    logic [31:0] mm [2][256];

    typedef struct {
        int          d;
        logic [31:0] addr;
        logic [31:0] exp_instr;
        logic        exp_fault;
    } vec_t;
    vec_t tbl [4];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endtask

    // Reference: a word store of 256 entries addressed by byte address.
    function automatic void model(input int d, input logic [31:0] a,
                                  output logic [31:0] ei, output logic ef);
`ifdef INSTR_MEM_PIPE_FAULT_EN
        ef = (a % 4 != 0) || (a >= 32'd1024);
        ei = ef ? 32'h0 : mm[d][a / 4];
`else
        ef = 1'b0;
        ei = mm[d][(a / 4) % 256];
`endif
    endfunction

    task automatic do_load(input int d, input logic [7:0] i, input logic [31:0] v);
        @(negedge clk);
        len[d] = 1'b1; laddr[d] = i; ldata[d] = v;
        @(posedge clk);
        #1 len[d] = 1'b0;
        mm[d][i] = v;
    endtask

    task automatic do_fetch(input int d, input logic [31:0] a, input logic [31:0] ei,
                            input logic ef, input string nm);
        int n;
        bit busy_ok;
        int w;
        w = (d == 0) ? 0 : 3;
        @(negedge clk);
        req[d] = 1'b1; faddr[d] = a;
        n = 0;
        while (!rdy[d] && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!rdy[d]) begin
            chk({nm, " accept timeout"}, 32'(rdy[d]), 32'd1);
            req[d] = 1'b0;
            return;
        end
        @(posedge clk);
        #1 req[d] = 1'b0;
        n = 1;
        busy_ok = 1'b1;
        while (!vld[d] && n < 40) begin
            if (rdy[d] || lrdy[d]) busy_ok = 1'b0;
            @(posedge clk);
            #1;
            n++;
        end
        chk({nm, " latency"}, 32'(n), 32'(w + 2));
        chk({nm, " busy"}, 32'(busy_ok), 32'd1);
        chk({nm, " instr"}, ins[d], ei);
        chk({nm, " fault"}, 32'(flt[d]), 32'(ef));
        @(posedge clk);
        #1;
        chk({nm, " pulse end"}, 32'(vld[d]), 32'd0);
        chk({nm, " hold"}, ins[d], ei);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] ei;
        logic        ef;
        logic [31:0] addrs [3];
        logic [31:0] bexp  [3];
        int          acc_cyc [$];
        logic [31:0] got [$];
        int          k;
        bit          saw;
        bit          a_now;

        tbl[0] = '{0, 32'h0,   32'h20042f5b, 1'b0};
        tbl[1] = '{1, 32'h4,   32'h2405cfc7, 1'b0};
`ifdef INSTR_MEM_PIPE_FAULT_EN
        tbl[2] = '{0, 32'h6,   32'h00000000, 1'b1};
        tbl[3] = '{0, 32'h400, 32'h00000000, 1'b1};
`else
        tbl[2] = '{0, 32'h6,   32'h2405cfc7, 1'b0};
        tbl[3] = '{0, 32'h400, 32'h20042f5b, 1'b0};
`endif

        for (int d = 0; d < 2; d++) begin
            req[d] = 1'b0; faddr[d] = '0; len[d] = 1'b0; laddr[d] = '0; ldata[d] = '0;
        end

        // Reset state.
        #12;
        for (int d = 0; d < 2; d++) begin
            chk("reset valid", 32'(vld[d]), 32'd0);
            chk("reset instr", ins[d], 32'h0);
            chk("reset fault", 32'(flt[d]), 32'd0);
        end
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            chk("post-reset fetch_ready", 32'(rdy[d]), 32'd1);
            chk("post-reset load_ready", 32'(lrdy[d]), 32'd1);
        end

        // Fill every word so no fetch ever reads an unwritten location.
        for (int i = 0; i < 256; i++) begin
            do_load(0, 8'(i), $urandom);
            do_load(1, 8'(i), $urandom);
        end
        for (int d = 0; d < 2; d++) begin
            do_load(d, 8'd0, 32'h20042f5b);
            do_load(d, 8'd1, 32'h2405cfc7);
        end

        for (int i = 0; i < 4; i++) begin
            do_fetch(tbl[i].d, tbl[i].addr, tbl[i].exp_instr, tbl[i].exp_fault, $sformatf("tbl%0d", i));
        end

        // Simultaneous load and fetch: the load wins, the fetch goes next cycle.
        @(negedge clk);
        len[0] = 1'b1; laddr[0] = 8'd2; ldata[0] = 32'h00053400;
        req[0] = 1'b1; faddr[0] = 32'h8;
        #1;
        chk("collide fetch_ready", 32'(rdy[0]), 32'd0);
        chk("collide load_ready", 32'(lrdy[0]), 32'd1);
        @(posedge clk);
        #1 len[0] = 1'b0;
        mm[0][2] = 32'h00053400;
        @(negedge clk);
        chk("collide next ready", 32'(rdy[0]), 32'd1);
        do_fetch(0, 32'h8, 32'h00053400, 1'b0, "collide fetch");

        // Reset during WAIT discards the fetch.
        @(negedge clk);
        req[1] = 1'b1; faddr[1] = 32'h4;
        @(posedge clk);
        #1 req[1] = 1'b0;
        @(posedge clk);
        #1 reset = 1'b0;
        saw = 1'b0;
        repeat (3) begin
            @(posedge clk);
            #1 if (vld[1]) saw = 1'b1;
        end
        reset = 1'b1;
        repeat (8) begin
            @(posedge clk);
            #1 if (vld[1]) saw = 1'b1;
        end
        chk("rst-wait no valid", 32'(saw), 32'd0);
        @(negedge clk);
        chk("rst-wait ready", 32'(rdy[1]), 32'd1);
        do_fetch(1, 32'h4, 32'h2405cfc7, 1'b0, "rst-wait refetch");

        // Back-to-back held request on the zero-wait instance.
        addrs[0] = 32'h0; addrs[1] = 32'h4; addrs[2] = 32'h8;
        bexp[0] = 32'h20042f5b; bexp[1] = 32'h2405cfc7; bexp[2] = 32'h00053400;
        k = 0;
        @(negedge clk);
        req[0] = 1'b1; faddr[0] = addrs[0];
        for (int c = 0; c < 12; c++) begin
            a_now = rdy[0] && req[0];
            @(posedge clk);
            #1;
            if (a_now) begin
                acc_cyc.push_back(c);
                k++;
                if (k < 3) faddr[0] = addrs[k];
                else req[0] = 1'b0;
            end
            if (vld[0]) got.push_back(ins[0]);
            @(negedge clk);
        end
        req[0] = 1'b0;
        chk("b2b accepts", 32'(acc_cyc.size()), 32'd3);
        for (int i = 1; i < acc_cyc.size(); i++)
            chk($sformatf("b2b spacing%0d", i), 32'(acc_cyc[i] - acc_cyc[i-1]), 32'd2);
        chk("b2b responses", 32'(got.size()), 32'd3);
        for (int i = 0; i < got.size() && i < 3; i++)
            chk($sformatf("b2b order%0d", i), got[i], bexp[i]);

        // Random traffic against the reference model.
        for (int i = 0; i < 60; i++) begin
            int d;
            logic [31:0] a;
            d = int'($urandom_range(1, 0));
            if ($urandom_range(2, 0) == 0) begin
                do_load(d, 8'($urandom), $urandom);
            end else begin
                case ($urandom_range(3, 0))
                    0, 1: a = {22'd0, 8'($urandom), 2'b00};
                    2: a = {22'd0, 8'($urandom), 2'($urandom_range(3, 1))};
                    default: a = $urandom | 32'h400;
                endcase
                model(d, a, ei, ef);
                do_fetch(d, a, ei, ef, $sformatf("rand%0d", i));
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
